// File: rtl/case5_sig_collector.sv
// Collects case5 {x,y,z} response vectors into a 16-bit MISR signature plus
// per-bit and per-vector counters; one run = NUM_VEC accepted vectors.
module case5_sig_bit_cnt (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [7:0] o_cnt
);
  logic [7:0] r_cnt;

  // NUM_VEC <= 255 keeps this below wrap, so no saturation logic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_cnt <= 8'd0;
    else if (i_clr) r_cnt <= 8'd0;
    else if (i_inc) r_cnt <= r_cnt + 8'd1;
  end

  assign o_cnt = r_cnt;
endmodule

module case5_sig_collector #(
  parameter int          NUM_VEC = 64,
  parameter logic [15:0] SEED    = 16'hFFFF,
  parameter logic [15:0] POLY    = 16'h1021
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_in_valid,
  input  logic [2:0]  i_in_xyz,
  output logic        o_in_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_sig,
  output logic [7:0]  o_cnt_x,
  output logic [7:0]  o_cnt_y,
  output logic [7:0]  o_cnt_z,
  output logic [7:0]  o_vec_cnt
);
  localparam int         NUM_LANES = 4;
  localparam logic [7:0] LAST_CNT  = 8'(NUM_VEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                         r_state;
  logic                           r_busy;
  logic                           r_done;
  logic [15:0]                    r_sig;
  logic                           w_acc;
  logic                           w_load;
  logic                           w_last;
  logic [15:0]                    w_sig_nxt;
  logic [NUM_LANES-1:0]           w_inc;
  logic [NUM_LANES-1:0][7:0]      w_cnt;

  // r_busy is the registered "in RUN" flag, so ready/accept need no decode.
  assign w_acc     = i_in_valid & r_busy;
  assign w_load    = i_start & (r_state != S_RUN);
  assign w_last    = w_acc & (w_cnt[3] == LAST_CNT);
  assign w_sig_nxt = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? POLY : 16'h0000)
                   ^ {13'b0, i_in_xyz};

  // Lane 3 counts every accept (vec_cnt); lanes 2..0 count x, y, z.
  assign w_inc = {w_acc, {3{w_acc}} & i_in_xyz};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    case5_sig_bit_cnt u_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_load),
      .i_inc   (w_inc[g]),
      .o_cnt   (w_cnt[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sig   <= 16'h0000;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_acc) r_sig <= w_sig_nxt;
          // Abort wins over completion; the final accept still lands.
          if (i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          if (i_start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_sig   <= SEED;
          end
        end
      endcase
    end
  end

  assign o_in_ready = r_busy;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_sig      = r_sig;
  assign o_cnt_x    = w_cnt[2];
  assign o_cnt_y    = w_cnt[1];
  assign o_cnt_z    = w_cnt[0];
  assign o_vec_cnt  = w_cnt[3];
endmodule

// File: tb/tb_case5_sig_collector.sv
// Random and directed stimulus for two collectors (NUM_VEC 64 and 4) sharing
// inputs, checked every cycle against a vector-list reference model.
module tb_case5_sig_collector;
  localparam logic [15:0] SEED = 16'hFFFF;
  localparam logic [15:0] POLY = 16'h1021;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [2:0] in_xyz = 3'd0;

  logic        rdy [2];
  logic        bsy [2];
  logic        dn  [2];
  logic [15:0] sig [2];
  logic [7:0]  cx [2], cy [2], cz [2], vc [2];

  int checks = 0;
  int errors = 0;

  // Reference model: the list of accepted vectors per run plus run/done flags.
  int          nv [2] = '{64, 4};
  bit          m_run [2], m_done [2], m_started [2];
  logic [2:0]  m_vec [2][256];
  int          m_n [2];

  always #5 clk = ~clk;

  case5_sig_collector #(.NUM_VEC(64), .SEED(SEED), .POLY(POLY)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_in_valid(in_valid), .i_in_xyz(in_xyz), .o_in_ready(rdy[0]),
    .o_busy(bsy[0]), .o_done(dn[0]), .o_sig(sig[0]), .o_cnt_x(cx[0]),
    .o_cnt_y(cy[0]), .o_cnt_z(cz[0]), .o_vec_cnt(vc[0]));

  case5_sig_collector #(.NUM_VEC(4), .SEED(SEED), .POLY(POLY)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_in_valid(in_valid), .i_in_xyz(in_xyz), .o_in_ready(rdy[1]),
    .o_busy(bsy[1]), .o_done(dn[1]), .o_sig(sig[1]), .o_cnt_x(cx[1]),
    .o_cnt_y(cy[1]), .o_cnt_z(cz[1]), .o_vec_cnt(vc[1]));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_sig(int k);
    logic [15:0] s;
    if (!m_started[k]) return 16'h0000;
    s = SEED;
    for (int i = 0; i < m_n[k]; i++)
      s = ((s << 1) ^ (s[15] ? POLY : 16'h0000)) ^ {13'b0, m_vec[k][i]};
    return s;
  endfunction

  function automatic logic [7:0] exp_cnt(int k, int b);
    int c = 0;
    for (int i = 0; i < m_n[k]; i++) if (m_vec[k][i][b]) c++;
    return 8'(c);
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_done[k] = 0; m_started[k] = 0; m_n[k] = 0;
    end
  endtask

  task automatic chk_all();
    for (int k = 0; k < 2; k++) begin
      string p = (k == 0) ? "n64" : "n4";
      chk({p, "_ready"}, 16'(rdy[k]), 16'(m_run[k]));
      chk({p, "_busy"},  16'(bsy[k]), 16'(m_run[k]));
      chk({p, "_done"},  16'(dn[k]),  16'(m_done[k]));
      chk({p, "_sig"},   sig[k],      exp_sig(k));
      chk({p, "_cnt_x"}, 16'(cx[k]),  16'(exp_cnt(k, 2)));
      chk({p, "_cnt_y"}, 16'(cy[k]),  16'(exp_cnt(k, 1)));
      chk({p, "_cnt_z"}, 16'(cz[k]),  16'(exp_cnt(k, 0)));
      chk({p, "_vec"},   16'(vc[k]),  16'(m_n[k]));
    end
  endtask

  // One clock: drive at negedge, advance the model, check after the edge.
  task automatic step(input bit st, input bit ab, input bit vl, input logic [2:0] xyz);
    @(negedge clk);
    start = st; abort = ab; in_valid = vl;
    in_xyz = vl ? xyz : 3'($urandom);
    for (int k = 0; k < 2; k++) begin
      bit acc = vl && m_run[k];
      if (acc) begin m_vec[k][m_n[k]] = in_xyz; m_n[k]++; end
      if (m_run[k]) begin
        if (ab) m_run[k] = 0;
        else if (acc && m_n[k] == nv[k]) begin m_run[k] = 0; m_done[k] = 1; end
      end else if (st) begin
        m_run[k] = 1; m_done[k] = 0; m_started[k] = 1; m_n[k] = 0;
      end
    end
    @(posedge clk); #1;
    chk_all();
  endtask

  initial begin
    int acc;
    mdl_reset();
    #12;
    chk_all();
    // First start right after release.
    @(negedge clk); rst_n = 1'b1;
    step(1, 0, 0, 0);
    // Completion on the 4-deep instance: four 111 with valid held.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 3'b111);
    chk("c4_done", 16'(dn[1]), 16'd1);
    chk("c4_ready", 16'(rdy[1]), 16'd0);
    chk("c4_cnt_x", 16'(cx[1]), 16'd4);
    chk("c4_vec", 16'(vc[1]), 16'd4);
    for (int i = 0; i < 10; i++) step(0, 0, 1'($urandom), 3'($urandom));
    chk("c4_hold_y", 16'(cy[1]), 16'd4);
    // Abort n64 run, then seed/first-accept check on both instances.
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 3'b101);
    chk("seed_first", sig[0], 16'hEFDA);
    chk("seed_first_n4", sig[1], 16'hEFDA);
    chk("seed_first_cy", 16'(cy[0]), 16'd0);
    // Toggled valid until n64 completes; start during RUN is ignored.
    acc = 1;
    for (int i = 0; i < 400 && acc < 64; i++) begin
      step(i == 5, 0, i[0], 3'($urandom));
      if (i[0]) acc++;
    end
    chk("tp_done", 16'(dn[0]), 16'd1);
    chk("tp_vec", 16'(vc[0]), 16'd64);
    // Abort coincident with the 11th accept.
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 3'($urandom));
    step(0, 1, 1, 3'b110);
    chk("abort_vec", 16'(vc[0]), 16'd11);
    chk("abort_done", 16'(dn[0]), 16'd0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("restart_sig", sig[0], SEED);
    chk("restart_vec", 16'(vc[0]), 16'd0);
    // Asynchronous reset at vector 20, between clock edges.
    for (int i = 0; i < 20; i++) step(0, 0, 1, 3'($urandom));
    @(negedge clk); in_valid = 1'b1; #2; rst_n = 1'b0; #1;
    mdl_reset();
    chk("arst_sig", sig[0], 16'h0000);
    chk("arst_vec", 16'(vc[0]), 16'd0);
    chk("arst_busy", 16'(bsy[0]), 16'd0);
    chk_all();
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    step(0, 0, 1, 3'b111);
    step(1, 0, 0, 0);
    for (int i = 0; i < 300 && !m_done[0]; i++)
      step(0, 0, ($urandom_range(0, 3) != 0), 3'($urandom));
    chk("full_done", 16'(dn[0]), 16'd1);
    // Random mix of start/abort/valid.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
           1'($urandom), 3'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
